// File: rtl/rotate_phase_gen.sv
// rotate_phase_gen: NCO phase front end that aligns each I/Q sample with its phase word.
// Optional truncation dither is enabled by defining ROTATE_PHASE_DITHER_EN.
module rotate_phase_gen #(
    parameter int ACC_WIDTH     = 24,
    parameter int DATA_WIDTH    = 16,
    parameter int FREQ_SYNC_SOF = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  ivalid,
    input  logic [DATA_WIDTH-1:0] in_i,
    input  logic [DATA_WIDTH-1:0] in_q,
    input  logic                  sof,
    input  logic [ACC_WIDTH-1:0]  freq_word,
    input  logic                  freq_load,
    input  logic [15:0]           phase_offset,
    output logic                  ovalid,
    output logic [DATA_WIDTH-1:0] out_i,
    output logic [DATA_WIDTH-1:0] out_q,
    output logic [15:0]           phase,
    output logic                  running
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH-1:0] fw_active;
    logic [ACC_WIDTH-1:0] fw_pending;
    logic                 pend_flag;

    logic                 sof_v;
    logic                 pend_eff;
    logic                 xfer;
    logic                 advance;
    logic [ACC_WIDTH-1:0] acc_base;
    logic [ACC_WIDTH-1:0] fw_cand;
    logic [ACC_WIDTH-1:0] fw_next;
    logic [ACC_WIDTH-1:0] trunc_src;
    logic [15:0]          phase_nxt;

`ifdef ROTATE_PHASE_DITHER_EN
    localparam int DITH_W = (ACC_WIDTH - 16 > 16) ? 16 : ACC_WIDTH - 16;

    logic [15:0]          lfsr;
    logic                 lfsr_fb;
    logic [ACC_WIDTH-1:0] dither;

    assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    // Dither source: steps once per accepted sample so the pattern tracks data, not time.
    always_ff @(posedge clock) begin
        if (reset) begin
            lfsr <= 16'hACE1;
        end else if (ivalid) begin
            lfsr <= {lfsr[14:0], lfsr_fb};
        end
    end

    // Zero-extend the low LFSR bits into the fractional part below the phase word.
    always_comb begin
        dither = '0;
        for (int i = 0; i < 16; i++) begin
            if (i < DITH_W) begin
                dither[i] = lfsr[i];
            end
        end
    end
`endif

    // Per-sample datapath: frame restart, frequency hand-over and phase word.
    always_comb begin
        sof_v    = ivalid && sof;
        acc_base = sof_v ? '0 : acc;
        pend_eff = freq_load || pend_flag;
        fw_cand  = freq_load ? freq_word : fw_pending;
        xfer     = ivalid && pend_eff && ((FREQ_SYNC_SOF == 0) || sof);
        fw_next  = xfer ? fw_cand : fw_active;
        advance  = ivalid && ((state == ST_RUN) || sof);
`ifdef ROTATE_PHASE_DITHER_EN
        trunc_src = acc_base + dither;
`else
        trunc_src = acc_base;
`endif
        phase_nxt = trunc_src[ACC_WIDTH-1 -: 16] + phase_offset;
    end

    // Accumulator, frequency registers and the time-aligned output bundle.
    always_ff @(posedge clock) begin
        if (reset) begin
            acc        <= '0;
            fw_active  <= '0;
            fw_pending <= '0;
            pend_flag  <= 1'b0;
            ovalid     <= 1'b0;
            out_i      <= '0;
            out_q      <= '0;
            phase      <= '0;
        end else begin
            ovalid <= ivalid;
            if (ivalid) begin
                out_i <= in_i;
                out_q <= in_q;
                phase <= phase_nxt;
            end
            if (advance) begin
                acc <= acc_base + fw_next;
            end
            fw_active <= fw_next;
            if (freq_load) begin
                fw_pending <= freq_word;
            end
            pend_flag <= pend_eff && !xfer;
        end
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: a valid sof starts the run, only reset ends it.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (ivalid && sof) state_nxt = ST_RUN;
            ST_RUN:  state_nxt = ST_RUN;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        running = (state == ST_RUN);
    end

endmodule

// File: tb/tb_rotate_phase_gen.sv
// tb_rotate_phase_gen: directed checks of rotate_phase_gen in the default build.
// Expected phases are hand-computed for ACC_WIDTH=24, FREQ_SYNC_SOF=1.
module tb_rotate_phase_gen;

    logic        clock = 1'b0;
    logic        reset;
    logic        ivalid;
    logic [15:0] in_i;
    logic [15:0] in_q;
    logic        sof;
    logic [23:0] freq_word;
    logic        freq_load;
    logic [15:0] phase_offset;
    logic        ovalid;
    logic [15:0] out_i;
    logic [15:0] out_q;
    logic [15:0] phase;
    logic        running;

    int n_cmp = 0;
    int n_err = 0;

    rotate_phase_gen #(
        .ACC_WIDTH(24),
        .DATA_WIDTH(16),
        .FREQ_SYNC_SOF(1)
    ) dut (
        .clock(clock),
        .reset(reset),
        .ivalid(ivalid),
        .in_i(in_i),
        .in_q(in_q),
        .sof(sof),
        .freq_word(freq_word),
        .freq_load(freq_load),
        .phase_offset(phase_offset),
        .ovalid(ovalid),
        .out_i(out_i),
        .out_q(out_q),
        .phase(phase),
        .running(running)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic samp(input logic v, input logic s, input logic [15:0] off);
        ivalid       = v;
        sof          = s;
        phase_offset = off;
        in_i         = in_i + 16'h0011;
        in_q         = in_q - 16'h0101;
        step();
    endtask

    task automatic load_idle(input logic [23:0] fw);
        ivalid    = 1'b0;
        sof       = 1'b0;
        freq_word = fw;
        freq_load = 1'b1;
        step();
        freq_load = 1'b0;
    endtask

    task automatic chk_out(input string tag, input logic [15:0] ph);
        chk({tag, ".ovalid"}, {31'd0, ovalid}, 32'd1);
        chk({tag, ".phase"}, {16'd0, phase}, {16'd0, ph});
        chk({tag, ".out_i"}, {16'd0, out_i}, {16'd0, in_i});
        chk({tag, ".out_q"}, {16'd0, out_q}, {16'd0, in_q});
    endtask

    initial begin
        reset        = 1'b1;
        ivalid       = 1'b1;
        in_i         = 16'h1000;
        in_q         = 16'h2000;
        sof          = 1'b0;
        freq_word    = '0;
        freq_load    = 1'b0;
        phase_offset = 16'h0000;

        step();
        step();
        step();
        reset  = 1'b0;
        ivalid = 1'b0;
        step();
        chk("rst.ovalid", {31'd0, ovalid}, 32'd0);
        chk("rst.phase", {16'd0, phase}, 32'd0);
        chk("rst.running", {31'd0, running}, 32'd0);
        chk("rst.out_i", {16'd0, out_i}, 32'd0);
        chk("rst.out_q", {16'd0, out_q}, 32'd0);

        load_idle(24'h010000);
        chk("idle.running", {31'd0, running}, 32'd0);
        samp(1'b1, 1'b1, 16'h0000);
        chk_out("f1.s0", 16'h0000);
        chk("f1.running", {31'd0, running}, 32'd1);
        samp(1'b1, 1'b0, 16'h0000);
        chk_out("f1.s1", 16'h0100);
        samp(1'b1, 1'b0, 16'h0000);
        chk_out("f1.s2", 16'h0200);
        samp(1'b1, 1'b0, 16'h0000);
        chk_out("f1.s3", 16'h0300);

        load_idle(24'h7F0000);
        samp(1'b1, 1'b1, 16'h0000);
        chk_out("f7f.s0", 16'h0000);
        samp(1'b1, 1'b0, 16'h0000);
        chk_out("f7f.s1", 16'h7F00);
        samp(1'b1, 1'b0, 16'h0000);
        chk_out("f7f.s2", 16'hFE00);
        samp(1'b1, 1'b0, 16'h0000);
        chk_out("f7f.s3", 16'h7D00);

        load_idle(24'h010000);
        samp(1'b1, 1'b1, 16'h0000);
        chk_out("sync.s0", 16'h0000);
        samp(1'b1, 1'b0, 16'h0000);
        chk_out("sync.s1", 16'h0100);
        freq_word = 24'h020000;
        freq_load = 1'b1;
        samp(1'b1, 1'b0, 16'h0000);
        freq_load = 1'b0;
        chk_out("sync.s2", 16'h0200);
        samp(1'b1, 1'b0, 16'h0000);
        chk_out("sync.s3", 16'h0300);
        samp(1'b1, 1'b1, 16'h0000);
        chk_out("sync.sof", 16'h0000);
        samp(1'b1, 1'b0, 16'h0000);
        chk_out("sync.new", 16'h0200);

        load_idle(24'h010000);
        samp(1'b1, 1'b1, 16'hFFFF);
        chk_out("gap.s0", 16'hFFFF);
        samp(1'b0, 1'b0, 16'hFFFF);
        chk("gap.g0.ovalid", {31'd0, ovalid}, 32'd0);
        chk("gap.g0.phase", {16'd0, phase}, 32'h0000FFFF);
        samp(1'b0, 1'b0, 16'hFFFF);
        chk("gap.g1.ovalid", {31'd0, ovalid}, 32'd0);
        samp(1'b1, 1'b0, 16'hFFFF);
        chk_out("gap.s1", 16'h00FF);

        reset = 1'b1;
        samp(1'b1, 1'b0, 16'h0000);
        chk("rrun.ovalid", {31'd0, ovalid}, 32'd0);
        chk("rrun.running", {31'd0, running}, 32'd0);
        chk("rrun.phase", {16'd0, phase}, 32'd0);
        reset = 1'b0;
        samp(1'b1, 1'b0, 16'h1234);
        chk_out("rrun.s0", 16'h1234);
        chk("rrun.idle", {31'd0, running}, 32'd0);
        samp(1'b1, 1'b0, 16'h1234);
        chk_out("rrun.s1", 16'h1234);

        samp(1'b0, 1'b1, 16'h0000);
        samp(1'b1, 1'b0, 16'h0000);
        chk("nosof.running", {31'd0, running}, 32'd0);
        chk_out("nosof.s0", 16'h0000);

        freq_word = 24'h030000;
        freq_load = 1'b1;
        samp(1'b1, 1'b1, 16'h0000);
        freq_load = 1'b0;
        chk_out("simul.s0", 16'h0000);
        samp(1'b1, 1'b0, 16'h0000);
        chk_out("simul.s1", 16'h0300);

        load_idle(24'hFF0000);
        samp(1'b1, 1'b1, 16'h0000);
        chk_out("neg.s0", 16'h0000);
        samp(1'b1, 1'b0, 16'h0000);
        chk_out("neg.s1", 16'hFF00);
        samp(1'b1, 1'b0, 16'h0000);
        chk_out("neg.s2", 16'hFE00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rotate_phase_gen.md
Name: rotate_phase_gen

Overview:
- Phase-accumulator (NCO) front end that sits directly upstream of the complex rotate stage.
- Per valid I/Q sample, emits the sample together with a signed 16-bit phase word, time-aligned on the same cycle.
- The rotate stage consumes phase, out_i, out_q and ovalid unchanged, so the chain works as a frequency shifter.
- Supports frame-synchronous phase reset, deferred frequency updates and a static phase offset.

Parameters:
- ACC_WIDTH, 24: phase accumulator width in bits (must be ≥16); output phase = acc[ACC_WIDTH-1 -: 16].
- DATA_WIDTH, 16: I/Q sample width.
- FREQ_SYNC_SOF, 1: 1 = pending frequency applied only at the next sof sample; 0 = applied at the next valid sample.

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- ivalid  input  1  input sample valid.
- in_i  input  DATA_WIDTH  input I sample.
- in_q  input  DATA_WIDTH  input Q sample.
- sof  input  1  start of frame; qualified by ivalid.
- freq_word  input  ACC_WIDTH  signed per-sample phase increment.
- freq_load  input  1  one-cycle strobe that captures freq_word into the pending register.
- phase_offset  input  16  signed offset added to the output phase, sampled with each valid sample.
- ovalid  output  1  output valid.
- out_i  output  DATA_WIDTH  registered copy of in_i.
- out_q  output  DATA_WIDTH  registered copy of in_q.
- phase  output  16  signed phase for the downstream rotate stage.
- running  output  1  high while the FSM is in RUN.

Behaviour:
- Reset (synchronous, active-high):
  - acc, fw_active, fw_pending, pend_flag, ovalid, out_i, out_q, phase and running all clear to 0.
  - FSM enters IDLE.
  - An in-flight sample is dropped: ovalid = 0 on the cycle after reset is asserted.
- Latency:
  - Exactly 1 cycle: ovalid(t+1) = ivalid(t) && !reset(t).
  - out_i, out_q and phase are registered together with ovalid.
  - While ovalid = 0, the output registers hold their previous values.
- FSM IDLE:
  - acc is held at 0; samples with ivalid = 1 pass with phase = phase_offset.
  - ivalid && sof moves the FSM to RUN.
- FSM RUN:
  - Every valid sample advances acc.
  - Remains in RUN until reset; there is no other exit.
- Phase computation, per valid sample n:
  - Let a = acc, except a = 0 when sof = 1.
  - phase = a[ACC_WIDTH-1 -: 16] + phase_offset, modulo 2^16 (wraps, no saturation).
  - Then acc <= a + fw_active, modulo 2^ACC_WIDTH.
  - So the first sample of a frame always carries phase_offset; sample k of the frame carries top16(k*fw) + offset.
- Frequency update:
  - freq_load sets pend_flag and captures freq_word into fw_pending.
  - A later freq_load before the pending value is applied overwrites it (last write wins).
  - FREQ_SYNC_SOF = 1: on a valid sof sample with pend_flag set, fw_active <= fw_pending and pend_flag clears. That sof sample's increment already uses the new value, i.e. acc <= 0 + fw_pending.
  - FREQ_SYNC_SOF = 0: the same transfer happens on any valid sample.
- Simultaneous events:
  - freq_load and a qualifying sample on the same cycle: the transfer uses the freq_word being loaded on that cycle.
  - sof while in RUN: acc restarts; there is no state change.
  - sof with ivalid = 0 is ignored.
- ivalid = 0: acc, fw_active and the FSM are unchanged (no phase advance during gaps).
- Width rule: freq_word is two's complement, so a negative increment gives a decreasing phase; wrap through 0x8000/0x7FFF is seamless.

Optional Feature:
- Macro: ROTATE_PHASE_DITHER_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1, seed 0xACE1 on reset) advances once per valid sample.
  - Its low ACC_WIDTH-16 bits are added to a before truncation, decorrelating phase truncation spurs.
  - acc itself is never dithered.
  - Ignored (no dither added) when ACC_WIDTH = 16.
- Not defined: no LFSR is present; phase is a pure truncation.

Test Plan:
- Reset held 3 cycles, then ivalid = 0 -> ovalid = 0, phase = 0, running = 0; out_i and out_q = 0.
- freq_word = 0x010000 with freq_load, then 4 valid samples with sof on the first, offset 0 -> phase 0x0000, 0x0100, 0x0200, 0x0300; out_i and out_q equal the inputs delayed 1 cycle; running = 1 after the first.
- freq_word = 0x7F0000 -> phases run 0x0000, 0x7F00, 0xFE00, 0x7D00 (wrap through 0x8000).
- FREQ_SYNC_SOF = 1: in RUN at fw = 0x010000, load 0x020000 mid-frame -> increments stay at 0x0100 until the next sof; that sample has phase 0x0000 and the next has 0x0200.
- phase_offset = 0xFFFF with a gapped ivalid (1,0,0,1) -> phases 0xFFFF, 0x00FF (no advance during the gap), ovalid only on the valid cycles.
- Reset asserted in RUN with ivalid = 1 -> ovalid = 0 next cycle, FSM IDLE, acc = 0; the next sample without sof has phase = phase_offset.
